mem_req_master: RTL and testbench
=================================

Name: mem_req_master

Overview:
- Initiator for the sparse memory request interface (req / wr_nrd / addr / din; busy / read_valid / dout / write_error).
- Accepts single commands over a valid/ready port and drives one memory transaction at a time, obeying the responder's busy handshake.
- Returns exactly one response per command (read data or write status) over a valid/ready port.
- Also provides a per-transaction timeout and saturating statistics counters. It sits between test or host logic and the memory.

Parameters:
- WIDTH_DATA, 8, data width.
- WIDTH_ADDR, 8, address width.
- TIMEOUT_CYCLES, 64, maximum cycles from issue to completion before the transaction is abandoned; must be ≥ 4.
- STAT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  WIDTH_ADDR  command address.
- cmd_data  in  WIDTH_DATA  write data (ignored for reads).
- mem_req  out  1  request to memory.
- mem_wr_nrd  out  1  operation to memory.
- mem_addr  out  WIDTH_ADDR  address to memory.
- mem_din  out  WIDTH_DATA  write data to memory.
- mem_busy  in  1  memory busy.
- mem_read_valid  in  1  read completion pulse.
- mem_dout  in  WIDTH_DATA  read data.
- mem_write_error  in  1  write rejected (memory full).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_wr  out  1  echo of cmd_wr.
- rsp_addr  out  WIDTH_ADDR  echo of cmd_addr.
- rsp_data  out  WIDTH_DATA  read data; 0 for writes and for errors.
- rsp_err  out  1  error: write_error, missing read_valid, or timeout.
- rsp_timeout  out  1  error cause was a timeout.
- stat_wr_cnt  out  STAT_WIDTH  completed writes, saturating.
- stat_rd_cnt  out  STAT_WIDTH  completed reads, saturating.
- stat_err_cnt  out  STAT_WIDTH  responses with rsp_err=1, saturating.

Behaviour:
- All outputs are registered.
- Reset values:
  - All outputs are 0, all counters are 0, and the FSM is in IDLE.
  - Exception: cmd_ready is 0 during reset and becomes 1 on the first cycle after rst deasserts.
  - rst asserted mid-transaction drops mem_req on the next edge, discards the command and any pending response, and does not update the counters.
- States and transitions:
  - IDLE
    - cmd_ready=1.
    - On cmd_valid&cmd_ready: latch cmd_wr/addr/data into mem_wr_nrd/mem_addr/mem_din; cmd_ready<=0; clear the timer; go to ISSUE.
  - ISSUE
    - Waits for mem_busy=0.
    - On mem_busy=0: mem_req<=1; go to ACK.
  - ACK
    - mem_req is held at 1, and mem_addr/mem_din/mem_wr_nrd are held stable.
    - When mem_busy=1 is sampled: mem_req<=0; go to DONE.
    - Address-0 fast path: if mem_read_valid=1 is sampled in ACK with mem_busy=0, treat it as completion and go directly to complete handling, same as DONE.
  - DONE
    - Waits for mem_busy=0. On that cycle, capture the result:
      - Read: rsp_data<=mem_dout if mem_read_valid=1; otherwise rsp_data<=0 and rsp_err<=1.
      - Write: rsp_data<=0; rsp_err<=mem_write_error.
    - rsp_valid<=1; go to RESP.
  - RESP
    - rsp_valid and all rsp_* fields are held stable until rsp_ready=1.
    - On handshake: rsp_valid<=0, rsp_err<=0, rsp_timeout<=0, cmd_ready<=1; go to IDLE.
- Timeout:
  - The timer counts every cycle in ISSUE/ACK/DONE.
  - When it reaches TIMEOUT_CYCLES: mem_req<=0; rsp_err<=1; rsp_timeout<=1; rsp_data<=0; go to RESP.
- Statistics counters:
  - Update on the cycle rsp_valid rises.
  - Read or write counter increments by rsp_wr; error counter increments on rsp_err.
  - Each counter saturates at all-ones.
- Latency:
  - An idle memory that asserts busy two cycles after req and completes N cycles later gives cmd accept → rsp_valid = N+4 cycles.
- Ordering and concurrency:
  - At most one transaction outstanding; no command is accepted while rsp_valid=1.
  - mem_req is never 1 while in DONE or RESP.

Test Plan:
- Reset: hold rst 3 cycles with cmd_valid=1 → mem_req=0, rsp_valid=0, stat_*=0, cmd_ready=0; cmd_ready=1 on the first cycle after release.
- Write then read: write addr=0x05 data=0xA5, then read addr=0x05 with memory model returning 0xA5 → write rsp_err=0, read rsp_data=0xA5, stat_wr_cnt=1, stat_rd_cnt=1.
- Write error: model pulses mem_write_error with busy falling on write addr=0x22 data=0x11 → rsp_err=1, rsp_timeout=0, stat_err_cnt=1.
- Timeout: mem_busy held 1 forever, read addr=0x10, TIMEOUT_CYCLES=64 → mem_req never rises; rsp_valid rises 64 cycles after ISSUE entry with rsp_err=1, rsp_timeout=1, rsp_data=0.
- Backpressure: rsp_ready=0 for 10 cycles after a read of 0x3C → rsp_* stable, cmd_ready=0, no new mem_req; accept occurs on the cycle rsp_ready=1.
- Reset mid-transaction: rst asserted in ACK → mem_req=0 next cycle, no response, counters unchanged.

Source files
------------

// File: rtl/mem_req_master.sv
// mem_req_master: single-outstanding initiator for the sparse memory port.
// Commands in, one response out per command, with timeout and stats.
module mem_req_master #(
    parameter int WIDTH_DATA     = 8,
    parameter int WIDTH_ADDR     = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [WIDTH_ADDR-1:0] cmd_addr,
    input  logic [WIDTH_DATA-1:0] cmd_data,
    output logic                  mem_req,
    output logic                  mem_wr_nrd,
    output logic [WIDTH_ADDR-1:0] mem_addr,
    output logic [WIDTH_DATA-1:0] mem_din,
    input  logic                  mem_busy,
    input  logic                  mem_read_valid,
    input  logic [WIDTH_DATA-1:0] mem_dout,
    input  logic                  mem_write_error,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_wr,
    output logic [WIDTH_ADDR-1:0] rsp_addr,
    output logic [WIDTH_DATA-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [STAT_WIDTH-1:0] stat_wr_cnt,
    output logic [STAT_WIDTH-1:0] stat_rd_cnt,
    output logic [STAT_WIDTH-1:0] stat_err_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ACK,
        DONE,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [TW-1:0]         timer_q, timer_d;
    logic                  cmd_ready_d;
    logic                  mem_req_d;
    logic                  mem_wr_nrd_d;
    logic [WIDTH_ADDR-1:0] mem_addr_d;
    logic [WIDTH_DATA-1:0] mem_din_d;
    logic                  rsp_valid_d;
    logic                  rsp_wr_d;
    logic [WIDTH_ADDR-1:0] rsp_addr_d;
    logic [WIDTH_DATA-1:0] rsp_data_d;
    logic                  rsp_err_d;
    logic                  rsp_timeout_d;
    logic [STAT_WIDTH-1:0] stat_wr_d, stat_rd_d, stat_err_d;

    logic                  in_flight;
    logic                  timeout_hit;
    logic                  fin_err;
    logic [WIDTH_DATA-1:0] fin_data;

    assign in_flight   = (state_q == ISSUE) || (state_q == ACK) ||
                         (state_q == DONE);
    assign timeout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // completion result, shared by DONE and the ACK fast path
    assign fin_err  = mem_wr_nrd ? mem_write_error : ~mem_read_valid;
    assign fin_data = (!mem_wr_nrd && mem_read_valid) ? mem_dout : '0;

    // next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        cmd_ready_d   = cmd_ready;
        mem_req_d     = mem_req;
        mem_wr_nrd_d  = mem_wr_nrd;
        mem_addr_d    = mem_addr;
        mem_din_d     = mem_din;
        rsp_valid_d   = rsp_valid;
        rsp_wr_d      = rsp_wr;
        rsp_addr_d    = rsp_addr;
        rsp_data_d    = rsp_data;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;
        stat_wr_d     = stat_wr_cnt;
        stat_rd_d     = stat_rd_cnt;
        stat_err_d    = stat_err_cnt;

        if (in_flight) begin
            timer_d = timer_q + TW'(1);
        end

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    mem_wr_nrd_d = cmd_wr;
                    mem_addr_d   = cmd_addr;
                    mem_din_d    = cmd_data;
                    rsp_wr_d     = cmd_wr;
                    rsp_addr_d   = cmd_addr;
                    cmd_ready_d  = 1'b0;
                    timer_d      = '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_busy) begin
                    mem_req_d = 1'b1;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (mem_busy) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end else if (mem_read_valid) begin
                    mem_req_d     = 1'b0;
                    rsp_data_d    = fin_data;
                    rsp_err_d     = fin_err;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
            end
            DONE: begin
                if (!mem_busy) begin
                    rsp_data_d    = fin_data;
                    rsp_err_d     = fin_err;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    cmd_ready_d   = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // an expiring timer overrides whatever the memory did this cycle
        if (in_flight && timeout_hit) begin
            mem_req_d     = 1'b0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_data_d    = '0;
            rsp_valid_d   = 1'b1;
            state_d       = RESP;
        end

        if (rsp_valid_d && !rsp_valid) begin
            if (rsp_wr) begin
                if (~&stat_wr_cnt) stat_wr_d = stat_wr_cnt + STAT_WIDTH'(1);
            end else begin
                if (~&stat_rd_cnt) stat_rd_d = stat_rd_cnt + STAT_WIDTH'(1);
            end
            if (rsp_err_d && ~&stat_err_cnt) begin
                stat_err_d = stat_err_cnt + STAT_WIDTH'(1);
            end
        end
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            cmd_ready    <= 1'b0;
            mem_req      <= 1'b0;
            mem_wr_nrd   <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
            rsp_valid    <= 1'b0;
            rsp_wr       <= 1'b0;
            rsp_addr     <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            rsp_timeout  <= 1'b0;
            stat_wr_cnt  <= '0;
            stat_rd_cnt  <= '0;
            stat_err_cnt <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cmd_ready    <= cmd_ready_d;
            mem_req      <= mem_req_d;
            mem_wr_nrd   <= mem_wr_nrd_d;
            mem_addr     <= mem_addr_d;
            mem_din      <= mem_din_d;
            rsp_valid    <= rsp_valid_d;
            rsp_wr       <= rsp_wr_d;
            rsp_addr     <= rsp_addr_d;
            rsp_data     <= rsp_data_d;
            rsp_err      <= rsp_err_d;
            rsp_timeout  <= rsp_timeout_d;
            stat_wr_cnt  <= stat_wr_d;
            stat_rd_cnt  <= stat_rd_d;
            stat_err_cnt <= stat_err_d;
        end
    end

endmodule

// File: tb/tb_mem_req_master.sv
// tb_mem_req_master: directed table, hand sequences and random traffic
// against a sparse memory responder and a transaction-level model.
module tb_mem_req_master;

    localparam int SW   = 4;
    localparam int SMAX = 15;
    localparam int TO   = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [7:0]    cmd_addr = 8'h00;
    logic [7:0]    cmd_data = 8'h00;
    logic          mem_req;
    logic          mem_wr_nrd;
    logic [7:0]    mem_addr;
    logic [7:0]    mem_din;
    logic          mem_busy;
    logic          mem_read_valid;
    logic [7:0]    mem_dout;
    logic          mem_write_error;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_wr;
    logic [7:0]    rsp_addr;
    logic [7:0]    rsp_data;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [SW-1:0] stat_wr_cnt;
    logic [SW-1:0] stat_rd_cnt;
    logic [SW-1:0] stat_err_cnt;

    // responder configuration, set by the main sequence
    int   cfg_gap  = 0;
    int   cfg_blen = 1;
    logic cfg_werr = 1'b0;
    logic cfg_drop = 1'b0;
    logic cfg_fast = 1'b0;
    logic hang     = 1'b0;
    logic pre_busy = 1'b0;
    logic r_busy;
    logic [7:0] ram [256];

    assign mem_busy = r_busy | pre_busy | hang;

    always #5 clk = ~clk;

    mem_req_master #(
        .WIDTH_DATA    (8),
        .WIDTH_ADDR    (8),
        .TIMEOUT_CYCLES(TO),
        .STAT_WIDTH    (SW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_wr         (cmd_wr),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .mem_req        (mem_req),
        .mem_wr_nrd     (mem_wr_nrd),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_busy       (mem_busy),
        .mem_read_valid (mem_read_valid),
        .mem_dout       (mem_dout),
        .mem_write_error(mem_write_error),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_wr         (rsp_wr),
        .rsp_addr       (rsp_addr),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .rsp_timeout    (rsp_timeout),
        .stat_wr_cnt    (stat_wr_cnt),
        .stat_rd_cnt    (stat_rd_cnt),
        .stat_err_cnt   (stat_err_cnt)
    );

    // sparse memory responder: gap, busy burst, then completion pulse
    initial begin : responder
        int phase, gcnt, bcnt;
        logic rwr;
        logic [7:0] raddr, rdin;
        phase = 0; gcnt = 0; bcnt = 0;
        rwr = 1'b0; raddr = 8'h00; rdin = 8'h00;
        r_busy = 1'b0;
        mem_read_valid = 1'b0;
        mem_write_error = 1'b0;
        mem_dout = 8'h00;
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hC3;
        forever begin
            @(negedge clk);
            mem_read_valid  = 1'b0;
            mem_write_error = 1'b0;
            mem_dout        = 8'h00;
            case (phase)
                0: if (mem_req) begin
                    rwr = mem_wr_nrd; raddr = mem_addr; rdin = mem_din;
                    if (cfg_fast && !rwr) begin
                        mem_read_valid = 1'b1;
                        mem_dout = ram[raddr];
                    end else begin
                        gcnt = cfg_gap; phase = 1;
                    end
                end
                1: if (gcnt > 0) gcnt--;
                   else begin r_busy = 1'b1; bcnt = cfg_blen; phase = 2; end
                2: if (bcnt > 1) bcnt--;
                   else begin
                       r_busy = 1'b0; phase = 0;
                       if (rwr) begin
                           mem_write_error = cfg_werr;
                           if (!cfg_werr) ram[raddr] = rdin;
                       end else if (!cfg_drop) begin
                           mem_read_valid = 1'b1;
                           mem_dout = ram[raddr];
                       end
                   end
                default: phase = 0;
            endcase
        end
    end

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        int         pre;
        int         gap;
        int         blen;
        logic       werr;
        logic       drop;
        logic       fast;
        int         hold;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    int m_wr = 0, m_rd = 0, m_err = 0;
    logic [7:0] ref_mem [256];
    vec_t tbl [11];

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int sat(int x);
        return (x < SMAX) ? x + 1 : x;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_stats(string tag);
        chk({tag, " stat_wr"},  32'(stat_wr_cnt),  32'(m_wr));
        chk({tag, " stat_rd"},  32'(stat_rd_cnt),  32'(m_rd));
        chk({tag, " stat_err"}, 32'(stat_err_cnt), 32'(m_err));
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int n;
        logic early, stable, se;
        logic [7:0] sd;
        n = 0;
        while (!cmd_ready && n < 100) begin step(); n++; end
        chk({tag, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
        cfg_gap = v.gap; cfg_blen = v.blen; cfg_werr = v.werr;
        cfg_drop = v.drop; cfg_fast = v.fast;
        cmd_valid = 1'b1; cmd_wr = v.wr;
        cmd_addr = v.addr; cmd_data = v.data;
        pre_busy = (v.pre > 0);
        step();
        cmd_valid = 1'b0;
        chk({tag, " cmd_ready busy"}, 32'(cmd_ready), 32'd0);
        early = 1'b0;
        for (int i = 0; i < v.pre; i++) begin
            step();
            if (mem_req) early = 1'b1;
        end
        pre_busy = 1'b0;
        if (v.pre > 0) chk({tag, " req under busy"}, 32'(early), 32'd0);
        n = 0;
        while (!rsp_valid && n < 200) begin step(); n++; end
        chk({tag, " rsp_valid"},   32'(rsp_valid),   32'd1);
        chk({tag, " rsp_wr"},      32'(rsp_wr),      32'(v.wr));
        chk({tag, " rsp_addr"},    32'(rsp_addr),    32'(v.addr));
        chk({tag, " rsp_data"},    32'(rsp_data),    32'(v.exp_data));
        chk({tag, " rsp_err"},     32'(rsp_err),     32'(v.exp_err));
        chk({tag, " rsp_timeout"}, 32'(rsp_timeout), 32'd0);
        chk({tag, " req in resp"}, 32'(mem_req),     32'd0);
        if (v.wr) m_wr = sat(m_wr);
        else m_rd = sat(m_rd);
        if (v.exp_err) m_err = sat(m_err);
        if (v.wr && !v.werr) ref_mem[v.addr] = v.data;
        chk_stats(tag);
        stable = 1'b1; sd = rsp_data; se = rsp_err;
        for (int i = 0; i < v.hold; i++) begin
            step();
            if (!rsp_valid || rsp_data !== sd || rsp_err !== se ||
                rsp_addr !== v.addr || cmd_ready || mem_req)
                stable = 1'b0;
        end
        if (v.hold > 0) chk({tag, " hold"}, 32'(stable), 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, " release"},
            32'({rsp_valid, cmd_ready, rsp_err, rsp_timeout}), 32'h4);
    endtask

    initial begin : main
        int n;
        logic seen;
        vec_t v;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hC3;

        //        wr    addr   data   pre gap bl werr  drop  fast hold err  data
        tbl[0]  = '{1'b1, 8'h05, 8'hA5, 0, 1, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 8'h05, 8'h00, 1, 0, 3, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'hA5};
        tbl[2]  = '{1'b1, 8'h22, 8'h11, 0, 0, 2, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'h00};
        tbl[3]  = '{1'b0, 8'h22, 8'h00, 0, 2, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'hE1};
        tbl[4]  = '{1'b1, 8'h3C, 8'h77, 2, 0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 8'h3C, 8'h00, 0, 1, 2, 1'b0, 1'b0, 1'b0, 10, 1'b0, 8'h77};
        tbl[6]  = '{1'b1, 8'h00, 8'h9E, 0, 0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 8'h00, 8'h00, 0, 0, 1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 8'h9E};
        tbl[8]  = '{1'b0, 8'h05, 8'h00, 0, 1, 2, 1'b0, 1'b1, 1'b0, 0, 1'b1, 8'h00};
        tbl[9]  = '{1'b1, 8'h05, 8'h5B, 3, 3, 6, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 8'h05, 8'h00, 0, 0, 4, 1'b0, 1'b0, 1'b0, 3, 1'b0, 8'h5B};

        // reset held with a command waiting
        rst = 1'b1; cmd_valid = 1'b1;
        repeat (3) step();
        chk("rst mem_req",   32'(mem_req),   32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
        chk_stats("rst");
        rst = 1'b0; cmd_valid = 1'b0;
        step();
        chk("post rst cmd_ready", 32'(cmd_ready), 32'd1);

        // reset while the request is waiting in ACK
        cfg_gap = 6; cfg_blen = 2; cfg_fast = 1'b0;
        cfg_drop = 1'b0; cfg_werr = 1'b0;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h10;
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin step(); n++; end
        chk("mid req up", 32'(mem_req), 32'd1);
        rst = 1'b1;
        step();
        chk("mid req drop", 32'(mem_req), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            step();
            if (rsp_valid || mem_req) seen = 1'b1;
        end
        chk("mid no rsp", 32'(seen), 32'd0);
        chk_stats("mid");

        for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // memory never releases busy
        hang = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin step(); n++; end
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h10;
        step();
        cmd_valid = 1'b0;
        n = 0; seen = 1'b0;
        while (!rsp_valid && n < 200) begin
            step(); n++;
            if (mem_req) seen = 1'b1;
        end
        chk("to latency",  32'(n),           32'(TO));
        chk("to mem_req",  32'(seen),        32'd0);
        chk("to err",      32'(rsp_err),     32'd1);
        chk("to timeout",  32'(rsp_timeout), 32'd1);
        chk("to data",     32'(rsp_data),    32'd0);
        chk("to addr",     32'(rsp_addr),    32'h10);
        m_rd = sat(m_rd); m_err = sat(m_err);
        chk_stats("to");
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        hang = 1'b0;
        chk("to release",
            32'({rsp_valid, cmd_ready, rsp_err, rsp_timeout}), 32'h4);

        // random traffic over a small address set
        for (int k = 0; k < 48; k++) begin
            v.wr   = 1'($urandom_range(0, 1));
            v.addr = 8'($urandom_range(0, 7));
            v.data = 8'($urandom);
            v.pre  = int'($urandom_range(0, 3));
            v.gap  = int'($urandom_range(0, 3));
            v.blen = int'($urandom_range(1, 6));
            v.werr = v.wr && ($urandom_range(0, 3) == 0);
            v.fast = !v.wr && (v.addr == 8'h00) &&
                     ($urandom_range(0, 1) == 1);
            v.drop = !v.wr && !v.fast && ($urandom_range(0, 4) == 0);
            v.hold = int'($urandom_range(0, 3));
            v.exp_err  = v.wr ? v.werr : v.drop;
            v.exp_data = (v.wr || v.drop) ? 8'h00 : ref_mem[v.addr];
            run_txn(v, $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
